// File: rtl/neuron_mac_acc.sv
// neuron_mac_acc: streaming sign-magnitude Q4.27 MAC with bias, saturating/wrapping output conversion
// Define MAC_SAT_EN to saturate overflowing results instead of wrapping them.
module neuron_mac_acc #(
  parameter int N_INPUTS = 8,
  parameter int ACC_W = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [31:0] x_in,
  input  logic [31:0] w_in,
  input  logic [31:0] bias,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic        ovf,
  output logic        busy
);
  localparam int CW = $clog2(N_INPUTS + 1);
  typedef enum logic [1:0] {IDLE, ACC, CONV, OUT} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic fire, done, conv_ovf;
  logic [30:0] prod_mag;
  logic [ACC_W-1:0] prod, bias_ext, acc, mag;
  logic [31:0] conv;
  // Product keeps bits [57:27] of the 62-bit magnitude product.
  assign prod_mag = 31'((62'(x_in[30:0]) * 62'(w_in[30:0])) >> 27);
  assign prod = (x_in[31] ^ w_in[31]) ? -ACC_W'(prod_mag) : ACC_W'(prod_mag);
  assign bias_ext = bias[31] ? -ACC_W'(bias[30:0]) : ACC_W'(bias[30:0]);
  assign mag = acc[ACC_W-1] ? -acc : acc;
  assign conv_ovf = |mag[ACC_W-1:31];
`ifdef MAC_SAT_EN
  assign conv = conv_ovf ? {acc[ACC_W-1], 31'h7FFFFFFF}
              : (mag[30:0] == '0) ? 32'h0 : {acc[ACC_W-1], mag[30:0]};
`else
  assign conv = (mag[30:0] == '0) ? 32'h0 : {acc[ACC_W-1], mag[30:0]};
`endif
  assign fire = in_valid & in_ready;
  assign cnt_nxt = (state == IDLE) ? CW'(1) : cnt + CW'(1);
  assign done = in_last | (cnt_nxt == CW'(N_INPUTS));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = fire ? (done ? CONV : ACC) : IDLE;
      ACC:  state_nxt = (fire && done) ? CONV : ACC;
      CONV: state_nxt = OUT;
      OUT:  state_nxt = out_ready ? IDLE : OUT;
    endcase
  end
  always_comb begin
    in_ready = ~rst & ((state == IDLE) | (state == ACC));
    out_valid = state == OUT;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      data_out <= '0;
      ovf <= 1'b0;
    end else begin
      if (fire) begin
        acc <= ((state == IDLE) ? bias_ext : acc) + prod;
        cnt <= cnt_nxt;
      end
      if (state == CONV) begin
        data_out <= conv;
        ovf <= conv_ovf;
      end
    end
endmodule
